// File: rtl/serial_word_feeder_pkg.sv
// Shared definitions for the serial word feeder and its bench.
package serial_word_feeder_pkg;

    // Default word length in bits. Legal range is 2..32.
    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_SHIFT = 2'd2
    } feeder_state_e;

endpackage : serial_word_feeder_pkg

// File: rtl/serial_word_feeder.sv
// Serial word feeder: takes a parallel word and emits it LSB first, one bit
// per cycle. Each word is preceded by a one-cycle clr pulse that restarts the
// downstream serial complementer.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no word in flight, ready to accept
// S_CLEAR | word captured, clr pulse to downstream this cycle
// S_SHIFT | shifting bits out; accepts the next word on the MSB cycle
module serial_word_feeder
    import serial_word_feeder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             areset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             clr,
    output logic             x,
    output logic             x_valid,
    output logic             x_last
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    feeder_state_e    state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic last_bit;
    logic accept;

    // The MSB cycle doubles as an accept slot so back-to-back words need
    // no idle cycle between them.
    assign last_bit = (state_q == S_SHIFT) && (cnt_q == CNT_LAST);
    assign in_ready = ~areset & ((state_q == S_IDLE) | last_bit);
    assign accept   = in_valid & in_ready;

    // Outputs decode registered state only, so in_valid/in_data never reach them.
    assign clr     = (state_q == S_CLEAR);
    assign x_valid = (state_q == S_SHIFT);
    assign x       = x_valid & shreg_q[0];
    assign x_last  = last_bit;

    // Next-state, shift register and bit counter update.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_CLEAR;
                    shreg_d = in_data;
                    cnt_d   = '0;
                end
            end
            S_CLEAR: begin
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                shreg_d = shreg_q >> 1;
                if (last_bit) begin
                    cnt_d = '0;
                    if (accept) begin
                        state_d = S_CLEAR;
                        shreg_d = in_data;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset drops any word in flight immediately.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule : serial_word_feeder

// File: tb/tb_serial_word_feeder.sv
// Scoreboard bench for serial_word_feeder: stimulus pushes the expected clr
// pulse and bit stream per accepted word, a monitor pops and compares.
module tb_serial_word_feeder;
    import serial_word_feeder_pkg::*;

    localparam int W = DEFAULT_WIDTH;

    logic         clk = 1'b0;
    logic         areset;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         clr;
    logic         x;
    logic         x_valid;
    logic         x_last;

    typedef struct {
        bit is_clr;
        bit xb;
        bit last;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   clr_times[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    serial_word_feeder #(.WIDTH(W)) dut (
        .clk      (clk),
        .areset   (areset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .clr      (clr),
        .x        (x),
        .x_valid  (x_valid),
        .x_last   (x_last)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Expected response of one accepted word: clr one cycle later, then W bits LSB first.
    function automatic void push_word(logic [W-1:0] w);
        exp_t e;
        e.is_clr = 1'b1; e.xb = 1'b0; e.last = 1'b0; e.cyc = cyc + 1;
        exp_q.push_back(e);
        for (int i = 0; i < W; i++) begin
            e.is_clr = 1'b0;
            e.xb     = w[i];
            e.last   = (i == W - 1);
            e.cyc    = 0;
            exp_q.push_back(e);
        end
    endfunction

    // Offer a word from a negedge; waited = extra cycles spent with in_ready low.
    task automatic send(input logic [W-1:0] w, input bit hold, output int waited);
        in_data  = w;
        in_valid = 1'b1;
        waited   = 0;
        #1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            chk("accept_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            push_word(w);
            #1;
            if (!hold) in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: compares every cycle's outputs against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (areset) begin
                chk("reset_quiet", {28'd0, clr, x, x_valid, x_last}, 32'd0);
            end else if (clr || x_valid) begin
                if (clr) clr_times.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", {30'd0, clr, x_valid}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_clr) begin
                        chk("clr", {31'd0, clr}, 32'd1);
                        chk("clr_x_valid", {30'd0, x_valid, x}, 32'd0);
                        chk("clr_latency", cyc, e.cyc);
                    end else begin
                        chk("x_valid", {31'd0, x_valid}, 32'd1);
                        chk("x_bit", {31'd0, x}, {31'd0, e.xb});
                        chk("x_last", {31'd0, x_last}, {31'd0, e.last});
                    end
                end
            end else begin
                chk("idle_quiet", {30'd0, x, x_last}, 32'd0);
                if (exp_q.size() != 0 && (!exp_q[0].is_clr || cyc >= exp_q[0].cyc)) begin
                    e = exp_q.pop_front();
                    chk("output_missing", {30'd0, clr, x_valid}, e.is_clr ? 32'd2 : 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int waited;
        areset   = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        #1;
        chk("rst_outputs", {28'd0, clr, x, x_valid, x_last}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        areset = 1'b0;
        #1;
        chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

        // Single word 8'h35: clr, then 1,0,1,0,1,1,0,0.
        @(negedge clk);
        send(8'h35, 1'b0, waited);
        drain();

        // Back-to-back 8'h01 then 8'hFF with in_valid held.
        clr_times.delete();
        send(8'h01, 1'b1, waited);
        @(negedge clk);
        send(8'hFF, 1'b0, waited);
        chk("b2b_wait", waited, 8);
        drain();
        if (clr_times.size() == 2) chk("clr_spacing", clr_times[1] - clr_times[0], W + 1);
        else chk("clr_count", clr_times.size(), 2);

        // Word offered mid-SHIFT (bit 3) waits for the x_last cycle.
        send(8'h35, 1'b0, waited);
        repeat (5) @(negedge clk);
        send(8'h80, 1'b0, waited);
        chk("midshift_wait", waited, 4);
        drain();

        // in_data changes after the accepting edge.
        send(8'h35, 1'b0, waited);
        @(negedge clk);
        in_data = 8'hCA;
        drain();

        // Reset mid-word after bit 2 of 8'hA5.
        send(8'hA5, 1'b0, waited);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2;
        areset = 1'b1;
        exp_q.delete();
        #1;
        chk("rst_mid_outputs", {28'd0, clr, x, x_valid, x_last}, 32'd0);
        chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        areset = 1'b0;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (12) @(negedge clk);
        chk("post_rst_residual", exp_q.size(), 0);

        // in_valid high during reset must not capture anything.
        areset   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("rst_valid_in_ready", {31'd0, in_ready}, 32'd0);
            chk("rst_valid_clr", {31'd0, clr}, 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        areset   = 1'b0;
        #1;
        chk("rst_valid_release_ready", {31'd0, in_ready}, 32'd1);
        repeat (12) @(negedge clk);
        chk("rst_valid_no_word", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_serial_word_feeder
